// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: ownership states and default sizes shared by the RAM arbiter files
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_e;
  localparam int MAX_BURST_DEF = 8;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: enable-driven up counter that sticks at all-ones, async active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (en_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester (CPU/DMA) single-port RAM arbiter with lockable bursts
module ram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          op0,
  input  logic          req1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          op1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] phy_ram_addr,
  output logic [DW-1:0] phy_ram_write,
  output logic          phy_ram_op,
  input  logic [DW-1:0] phy_ram_read,
  output logic [15:0]   wait_cnt
);
  localparam int BW = $clog2(MAX_BURST) + 1;
  arb_state_e state_q, state_d;
  logic last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic idle, own, o_req, o_lock, o_op, x_req, mmio, burst_done;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata;
  always_comb begin
    idle       = state_q == IDLE;
    own        = state_q == OWN1;
    o_req      = own ? req1 : req0;
    o_lock     = own ? lock1 : lock0;
    o_op       = own ? op1 : op0;
    o_addr     = own ? addr1 : addr0;
    o_wdata    = own ? wdata1 : wdata0;
    x_req      = own ? req0 : req1;
    mmio       = o_addr[AW-1];
    // the current access is the MAX_BURST-th one when the counter shows MAX_BURST-1
    burst_done = burst_q >= BW'(MAX_BURST - 1);
  end
  always_comb begin
    state_d = state_q;
    if (idle)
      state_d = (req0 && req1) ? (last_q ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
    else if (!o_req || (x_req && (!o_lock || burst_done)))
      state_d = x_req ? (own ? OWN0 : OWN1) : IDLE;
    burst_d = (state_d != state_q || idle || !x_req) ? '0 :
              (o_req && burst_q != '1) ? burst_q + 1'b1 : burst_q;
    last_d  = (state_d != state_q && state_d != IDLE) ? (state_d == OWN1) : last_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  assign gnt0          = state_q == OWN0;
  assign gnt1          = state_q == OWN1;
  assign phy_ram_addr  = (idle || mmio) ? '0 : o_addr;
  assign phy_ram_write = idle ? '0 : o_wdata;
  assign phy_ram_op    = !idle && o_req && !mmio && o_op;
  assign rdata0        = (gnt0 && !addr0[AW-1]) ? phy_ram_read : '0;
  assign rdata1        = (gnt1 && !addr1[AW-1]) ? phy_ram_read : '0;
  sat_counter #(.W(16)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  ((req0 && !gnt0) || (req1 && !gnt1)),
    .cnt_o (wait_cnt)
  );
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a cycle-level ownership model
module tb_ram_arbiter;
  localparam int MB = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 0, lock0 = 0, op0 = 0, req1 = 0, lock1 = 0, op1 = 0;
  logic [15:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0, phy_ram_read = 0;
  logic gnt0, gnt1, phy_ram_op;
  logic [15:0] rdata0, rdata1, phy_ram_addr, phy_ram_write, wait_cnt;
  int n_chk = 0, n_pass = 0;
  int m_own, m_last, m_run, m_wc;
  int n;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0), .op0(op0),
    .req1(req1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .phy_ram_addr(phy_ram_addr), .phy_ram_write(phy_ram_write), .phy_ram_op(phy_ram_op),
    .phy_ram_read(phy_ram_read), .wait_cnt(wait_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Checks the current cycle against the model, then advances the model across the next edge.
  task automatic step();
    int own, o, nxt;
    logic [15:0] oa, ow;
    logic oreq, oop, mm;
    logic [1:0] rq, lk;
    @(negedge clk);
    own  = m_own;
    oa   = (own == 1) ? addr1 : addr0;
    ow   = (own == 1) ? wdata1 : wdata0;
    oreq = (own == 1) ? req1 : req0;
    oop  = (own == 1) ? op1 : op0;
    mm   = oa[15];
    chk("gnt0", gnt0, own == 0);
    chk("gnt1", gnt1, own == 1);
    chk("phy_addr", phy_ram_addr, (own < 0 || mm) ? 16'h0 : oa);
    chk("phy_write", phy_ram_write, (own < 0) ? 16'h0 : ow);
    chk("phy_op", phy_ram_op, own >= 0 && oreq && !mm && oop);
    chk("rdata0", rdata0, (own == 0 && !addr0[15]) ? phy_ram_read : 16'h0);
    chk("rdata1", rdata1, (own == 1 && !addr1[15]) ? phy_ram_read : 16'h0);
    chk("wait_cnt", wait_cnt, m_wc);
    rq = {req1, req0};
    lk = {lock1, lock0};
    if (((req0 && own != 0) || (req1 && own != 1)) && m_wc < 65535) m_wc++;
    if (own < 0) nxt = (req0 && req1) ? (m_last == 1 ? 0 : 1) : req0 ? 0 : req1 ? 1 : -1;
    else begin
      o = 1 - own;
      if (!rq[own]) nxt = rq[o] ? o : -1;
      else if (rq[o] && (!lk[own] || m_run + 1 >= MB)) nxt = o;
      else nxt = own;
    end
    if (nxt != own) m_run = 0;
    else if (own >= 0 && rq[0] && rq[1]) m_run++;
    else m_run = 0;
    if (nxt >= 0 && nxt != own) m_last = nxt;
    m_own = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_op", phy_ram_op, 0);
    chk("rst_wait", wait_cnt, 0);
    {req0, req1, lock0, lock1} = '0;
    m_own = -1; m_last = 1; m_run = 0; m_wc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    // single CPU write into RAM space
    req0 = 1; addr0 = 16'h0010; op0 = 1; wdata0 = 16'hBEEF;
    step();
    chk("s1_gnt0", gnt0, 1);
    chk("s1_op", phy_ram_op, 1);
    chk("s1_addr", phy_ram_addr, 16'h0010);
    step();
    // owner targets MMIO space
    addr0 = 16'h8001; phy_ram_read = 16'h1234;
    #1;
    chk("mmio_op", phy_ram_op, 0);
    chk("mmio_addr", phy_ram_addr, 0);
    chk("mmio_rdata", rdata0, 0);
    step();
    // unlocked contention alternates
    do_reset();
    req0 = 1; req1 = 1; addr0 = 16'h0100; addr1 = 16'h0200; op0 = 0; op1 = 1;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("alt_gnt0", gnt0, (i % 2) == 0);
      step();
    end
    // locked DMA burst against a waiting CPU
    do_reset();
    req1 = 1; lock1 = 1; addr1 = 16'h0020; op1 = 1;
    step();
    req0 = 1;
    n = 0;
    for (int i = 0; i < 20 && gnt1; i++) begin
      n++;
      step();
    end
    chk("burst_len", n, MB);
    chk("after_burst", gnt0, 1);
    // reset in the middle of a burst
    do_reset();
    req1 = 1; lock1 = 1; op1 = 1; addr1 = 16'h0030;
    step();
    req0 = 1;
    step();
    step();
    chk("pre_rst_op", phy_ram_op, 1);
    do_reset();
    req0 = 1; req1 = 1; lock1 = 0;
    step();
    chk("tie_gnt0", gnt0, 1);
    chk("tie_gnt1", gnt1, 0);
    // random traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      req0 = $urandom_range(0, 3) != 0;
      req1 = $urandom_range(0, 3) != 0;
      lock0 = $urandom_range(0, 1);
      lock1 = $urandom_range(0, 1);
      op0 = $urandom_range(0, 1);
      op1 = $urandom_range(0, 1);
      addr0 = 16'($urandom) & (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'h7FFF);
      addr1 = 16'($urandom) & (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'h7FFF);
      wdata0 = 16'($urandom);
      wdata1 = 16'($urandom);
      phy_ram_read = 16'($urandom);
      step();
    end
    // wait counter saturation
    do_reset();
    req0 = 1; req1 = 1; lock0 = 0; lock1 = 0;
    for (int i = 0; i < 65540; i++) step();
    chk("wait_sat", wait_cnt, 16'hFFFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 8: maximum consecutive accesses one owner keeps while the other requester waits.
REQ-002 Parameter AW, default 16: address width.
REQ-003 Parameter DW, default 16: data width.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 reqN  input  1  requester N (N=0 CPU, N=1 DMA) wants the RAM port.
REQ-007 lockN  input  1  requester N asks to keep ownership for a burst.
REQ-008 addrN  input  AW  requester N address.
REQ-009 wdataN  input  DW  requester N write data.
REQ-010 opN  input  1  requester N op: 1 write, 0 read.
REQ-011 gntN  output  1  requester N owns the port this cycle.
REQ-012 rdataN  output  DW  read data to requester N.
REQ-013 phy_ram_addr  output  AW  physical RAM address.
REQ-014 phy_ram_write  output  DW  physical RAM write data.
REQ-015 phy_ram_op  output  1  physical RAM write strobe.
REQ-016 phy_ram_read  input  DW  physical RAM combinational read data.
REQ-017 wait_cnt  output  16  cycles any requester waited while requesting.

Function
REQ-018 State register SHALL take values IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1), both registered-state decodes.
REQ-019 An access by requester N SHALL occur in every cycle with gntN=1 and reqN=1; gntN=1 with reqN=0 SHALL produce no RAM write.
REQ-020 In IDLE, a single requester N SHALL enter OWNN at the next edge (one-cycle grant latency).
REQ-021 In IDLE with both requesting, the requester other than last_owner SHALL win.
REQ-022 In OWNN, reqN=0 SHALL move to OWN(other) if the other requests, else IDLE, at the next edge.
REQ-023 In OWNN with reqN=1, other requesting, lockN=0: ownership SHALL pass to other at the next edge (strict alternation, one access per grant).
REQ-024 In OWNN with reqN=1, lockN=1, other requesting: SHALL stay until burst_cnt reaches MAX_BURST, then pass to other at the next edge regardless of lock.
REQ-025 burst_cnt SHALL increment on each access by owner while other requests, clear on every ownership change and when other is not requesting; width clog2(MAX_BURST)+1, never wraps.
REQ-026 last_owner SHALL update to N on every entry into OWNN.
REQ-027 phy_ram_addr/phy_ram_write/phy_ram_op SHALL be combinational muxes of the owner's inputs; in IDLE all three SHALL be 0.
REQ-028 phy_ram_op SHALL be 0 whenever owner addr[AW-1]=1 (MMIO space, decoded elsewhere) or owner req=0; phy_ram_addr SHALL be 0 for MMIO addresses.
REQ-029 rdataN SHALL equal phy_ram_read when gntN=1 and addrN[AW-1]=0, else 0.
REQ-030 wait_cnt SHALL increment by 1 per cycle in which (req0 & !gnt0) | (req1 & !gnt1), saturating at 16'hFFFF.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, gnt0=gnt1=0, burst_cnt=0, wait_cnt=0, last_owner=1 (so req0 wins the first tie).
REQ-032 Reset mid-burst SHALL abandon the burst with no further phy_ram_op pulse; operation resumes from IDLE on the first edge after rst_n rises.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1), default MAX_BURST, AW, DW.
REQ-034 One sub-module sat_counter (parameterised width, enable, saturating, async active-low clear) SHALL implement wait_cnt; FSM and muxes stay in ram_arbiter.

Verification
REQ-035 Reset, then req0=1 alone, addr0=16'h0010 op0=1 wdata0=16'hBEEF -> gnt0=1 one cycle later, phy_ram_op=1, phy_ram_addr=16'h0010.
REQ-036 req0=req1=1 from IDLE after reset, lock=0 -> gnt pattern 0,1,0,1...; wait_cnt +1 per cycle.
REQ-037 lock1=1 with req0 held, MAX_BURST=8 -> gnt1 exactly 8 cycles, then gnt0 on cycle 9.
REQ-038 owner addr=16'h8001 op=1 -> phy_ram_op=0, phy_ram_addr=0, rdata=0.
REQ-039 rst_n pulled low at burst cycle 3 -> gnt1, phy_ram_op drop same cycle; after release, req0/req1 tie grants req0.
REQ-040 force wait_cnt to 16'hFFFE, hold req1 blocked 3 cycles -> reads 16'hFFFF, no wrap.
